lshift_arbiter: RTL and testbench
=================================

// Module: lshift_arbiter
// PURPOSE
//  Shares one lshifter instance (barrel left shifter) between two requesters.
//  Round-robin arbitration over valid/ready request channels.
//  Result is registered into a single-entry output slot with a valid/ready handshake.
//  Sits between the two producer blocks and the shift-result consumer.
// PARAMETERS
//  data_width  8  operand/result width; must equal 2**shift_len (lshifter stage structure)
//  shift_len   3  shift-amount width; shift range 0..data_width-1
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           asynchronous, active-high reset
//  req0_valid  in   1           requester 0 has an operand
//  req0_ready  out  1           requester 0 operand accepted this cycle
//  req0_data   in   data_width  requester 0 operand
//  req0_bits   in   shift_len   requester 0 shift amount
//  req1_valid  in   1           requester 1 has an operand
//  req1_ready  out  1           requester 1 operand accepted this cycle
//  req1_data   in   data_width  requester 1 operand
//  req1_bits   in   shift_len   requester 1 shift amount
//  out_valid   out  1           out_data/out_id hold a result
//  out_ready   in   1           consumer takes result this cycle
//  out_data    out  data_width  data << bits, upper bits discarded, zero fill
//  out_id      out  1           requester that owns the result (0/1)
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_id=0, state=EMPTY, last_grant=1.
//    This gives req0 priority first. Any held result is dropped.
//    req*_ready=0 while rst=1.
//  - States: EMPTY (slot free), FULL (slot holds unconsumed result).
//    EMPTY->FULL on accept.
//    FULL->EMPTY on out_ready with no accept.
//    FULL->FULL on out_ready with same-cycle accept, or on !out_ready.
//  - can_accept = (state==EMPTY) | out_ready. Enables pass-through at 1 result/cycle.
//  - Grant (combinational):
//    only one valid -> that requester;
//    both valid -> requester != last_grant;
//    none -> no grant.
//  - reqN_ready = grantN & can_accept. At most one ready high per cycle.
//    Ready does not depend on out_valid of a non-consumed slot beyond can_accept.
//  - Accept = reqN_valid & reqN_ready. On accept edge:
//    out_data <= lshifter(reqN_data, reqN_bits); out_id <= N; last_grant <= N; out_valid <= 1.
//  - Latency: operand accepted at edge k -> result visible after edge k, out_valid=1.
//  - Stall: while out_valid & !out_ready, out_data/out_id are held stable and both readies are 0.
//  - last_grant updates only on accept. A stalled or absent requester does not move the pointer.
//  - Requester holds data/bits stable while valid & !ready. The block does not check this.
//  - Shift: bits=0 passes data through; bits=data_width-1 leaves only data[0] in MSB.
// TESTING
//  1. Reset with both valid -> after rst deassert, req0_ready=1 first.
//     req0 data=8'hA5 bits=3 -> next cycle out_data=8'h28, out_id=0.
//  2. Both valid continuously, out_ready=1 -> grants alternate 0,1,0,1.
//     One result per cycle; out_id sequence matches.
//  3. Single req1 valid only, repeated 3 times -> granted every cycle.
//     last_grant=1, then req0 arrives with req1 -> req0 granted.
//  4. out_ready=0 with slot full -> both readies 0; out_data stable for 5 cycles.
//     Raise out_ready -> same-cycle accept of the next operand, no bubble.
//  5. Shift edges: data=8'hFF bits=0 -> 8'hFF; bits=7 -> 8'h80; data=8'h01 bits=7 -> 8'h80.
//  6. rst asserted mid-stall with out_valid=1 -> out_valid=0 immediately (async).
//     After release, req0 has priority again.

Source files
------------

// File: rtl/lshift_arbiter.sv
// Two-requester round-robin arbiter sharing one barrel left shifter.
// The result lands in a single-entry output slot with a valid/ready handshake.
module lshift_arbiter #(
  parameter int unsigned data_width = 8,
  parameter int unsigned shift_len  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [data_width-1:0] req0_data,
  input  logic [shift_len-1:0]  req0_bits,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [data_width-1:0] req1_data,
  input  logic [shift_len-1:0]  req1_bits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_id
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_q, state_d;
  logic                  last_grant;
  logic                  grant0, grant1;
  logic                  can_accept;
  logic                  accept;
  logic [data_width-1:0] sel_data;
  logic [shift_len-1:0]  sel_bits;
  logic [data_width-1:0] shifted;

  // Barrel shifter: stage i shifts by 2**i when bit i of the amount is set.
  function automatic logic [data_width-1:0] lshifter(
    input logic [data_width-1:0] d,
    input logic [shift_len-1:0]  b
  );
    logic [data_width-1:0] s;
    s = d;
    for (int unsigned i = 0; i < shift_len; i++) begin
      if (b[i]) s = s << (1 << i);
    end
    return s;
  endfunction

  // Round-robin: on contention, the requester not granted last time wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_comb begin
    sel_data = grant1 ? req1_data : req0_data;
    sel_bits = grant1 ? req1_bits : req0_bits;
    shifted  = lshifter(sel_data, sel_bits);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid  = (state_q == FULL);
    can_accept = (state_q == EMPTY) | out_ready;
    req0_ready = grant0 & can_accept & ~rst;
    req1_ready = grant1 & can_accept & ~rst;
    accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_data   <= shifted;
      out_id     <= grant1;
      last_grant <= grant1;
    end
  end

endmodule

// File: tb/tb_lshift_arbiter.sv
// Directed self-checking bench for lshift_arbiter.
module tb_lshift_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_data;
  logic [2:0] req0_bits;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_data;
  logic [2:0] req1_bits;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_id;

  int n_cmp = 0;
  int n_err = 0;

  lshift_arbiter #(.data_width(8), .shift_len(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_bits(req0_bits),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_bits(req1_bits),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic id);
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk8({tag, "_data"}, out_data, d);
    chk1({tag, "_id"}, out_id, id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_bits = '0;
    req1_valid = 1'b0; req1_data = '0; req1_bits = '0;
    out_ready = 1'b0;
    tick(); tick();

    // 1: both valid during reset, req0 wins first after release
    req0_valid = 1'b1; req0_data = 8'hA5; req0_bits = 3'd3;
    req1_valid = 1'b1; req1_data = 8'h0F; req1_bits = 3'd1;
    out_ready = 1'b1;
    #1;
    chk1("rst_r0_ready", req0_ready, 1'b0);
    chk1("rst_r1_ready", req1_ready, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk8("rst_data", out_data, 8'h00);
    chk1("rst_id", out_id, 1'b0);
    rst = 1'b0;
    #1;
    chk1("t1_r0_ready", req0_ready, 1'b1);
    chk1("t1_r1_ready", req1_ready, 1'b0);
    tick();
    chk_out("t1_out", 8'h28, 1'b0);

    // 2: continuous contention alternates grants, one result per cycle
    req0_data = 8'h81; req0_bits = 3'd1;
    chk1("t2a_r1_ready", req1_ready, 1'b1);
    chk1("t2a_r0_ready", req0_ready, 1'b0);
    tick();
    chk_out("t2a_out", 8'h1E, 1'b1);
    req1_data = 8'h33; req1_bits = 3'd2;
    chk1("t2b_r0_ready", req0_ready, 1'b1);
    tick();
    chk_out("t2b_out", 8'h02, 1'b0);
    chk1("t2c_r1_ready", req1_ready, 1'b1);
    tick();
    chk_out("t2c_out", 8'hCC, 1'b1);

    // 3: lone req1 granted every cycle, then req0 wins contention
    req0_valid = 1'b0;
    req1_data = 8'h01; req1_bits = 3'd0;
    #1;
    chk1("t3a_r1_ready", req1_ready, 1'b1);
    tick();
    chk_out("t3a_out", 8'h01, 1'b1);
    req1_data = 8'h03; req1_bits = 3'd1;
    #1;
    chk1("t3b_r1_ready", req1_ready, 1'b1);
    tick();
    chk_out("t3b_out", 8'h06, 1'b1);
    req1_data = 8'h07; req1_bits = 3'd2;
    #1;
    chk1("t3c_r1_ready", req1_ready, 1'b1);
    tick();
    chk_out("t3c_out", 8'h1C, 1'b1);
    req0_valid = 1'b1; req0_data = 8'h11; req0_bits = 3'd4;
    #1;
    chk1("t3d_r0_ready", req0_ready, 1'b1);
    chk1("t3d_r1_ready", req1_ready, 1'b0);
    tick();
    chk_out("t3d_out", 8'h10, 1'b0);

    // 4: stall holds the slot and blocks both readies; release has no bubble
    out_ready = 1'b0;
    req0_data = 8'h44; req0_bits = 3'd1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk1("t4_r0_ready", req0_ready, 1'b0);
      chk1("t4_r1_ready", req1_ready, 1'b0);
      chk_out("t4_hold", 8'h10, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk1("t4_rel_r1_ready", req1_ready, 1'b1);
    chk1("t4_rel_r0_ready", req0_ready, 1'b0);
    tick();
    chk_out("t4_rel_out", 8'h1C, 1'b1);

    // 5: shift edges through req0 alone
    req1_valid = 1'b0;
    req0_data = 8'hFF; req0_bits = 3'd0;
    tick();
    chk_out("t5_ff_0", 8'hFF, 1'b0);
    req0_data = 8'hFF; req0_bits = 3'd7;
    tick();
    chk_out("t5_ff_7", 8'h80, 1'b0);
    req0_data = 8'h01; req0_bits = 3'd7;
    tick();
    chk_out("t5_01_7", 8'h80, 1'b0);
    req0_data = 8'h80; req0_bits = 3'd1;
    tick();
    chk_out("t5_80_1", 8'h00, 1'b0);

    // 6: async reset mid-stall drops the result; req0 priority restored
    req0_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_out("t6_stall", 8'h00, 1'b0);
    req0_valid = 1'b1; req0_data = 8'h05; req0_bits = 3'd1;
    req1_valid = 1'b1; req1_data = 8'h09; req1_bits = 3'd0;
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_rst_valid", out_valid, 1'b0);
    chk8("t6_rst_data", out_data, 8'h00);
    chk1("t6_rst_r0_ready", req0_ready, 1'b0);
    chk1("t6_rst_r1_ready", req1_ready, 1'b0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk1("t6_r0_ready", req0_ready, 1'b1);
    chk1("t6_r1_ready", req1_ready, 1'b0);
    tick();
    chk_out("t6_out", 8'h0A, 1'b0);

    // drain: consumed slot with no new accept goes empty
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk1("drain_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
